fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Next-generation instruction fetch unit. Owns its own fetch PC and prefetches sequential words
//  over the shared memory bus into a DEPTH-entry FIFO. Hands {pc, instr} to decode via valid/ready
//  and supports redirect (flush), so core stalls no longer serialise fetch. Sits between core
//  control and the memory bus arbiter, at the same place as the single-shot fetch stage.
// PARAMETERS
//  DEPTH     4      queue entries; power of two, >= 2
//  PC_STEP   4      fetch PC increment per request (bytes)
//  RESET_PC  32'h0  fetch PC after reset
// PORTS
//  clk              in   1   clock, all state on posedge
//  rstn             in   1   asynchronous active-low reset
//  flush            in   1   redirect: drop queue + in-flight word, restart at redirect_pc
//  redirect_pc      in   32  new fetch PC, sampled when flush=1
//  request_enable   out  1   bus request strobe, one-cycle pulse
//  mode             out  1   bus mode, always MEMREQ_READ
//  addr             out  32  bus address, held until the next request
//  wdata            out  32  constant 0
//  wstrb            out  4   constant 0
//  response_enable  in   1   bus read-data valid, one cycle
//  data             in   32  bus read data
//  instr_valid      out  1   queue non-empty
//  instr_ready      in   1   consumer accepts head entry when instr_valid & instr_ready
//  instr_raw        out  32  head entry instruction word
//  instr_pc         out  32  head entry PC
//  count            out  $clog2(DEPTH)+1  entries currently held
// BEHAVIOUR
//  Reset: state=IDLE; fetch_pc=RESET_PC; discard=0; rd/wr ptrs=0; count=0; request_enable=0;
//   mode=MEMREQ_READ; addr=0; instr_valid=0. Reset mid-request abandons it. No flush is needed.
//  FSM, one outstanding bus request max:
//   IDLE: if !flush && count<DEPTH, set request_enable<=1, addr<=fetch_pc,
//         fetch_pc<=fetch_pc+PC_STEP (mod 2^32), and go to WAIT. response_enable in IDLE is ignored.
//   WAIT: request_enable<=0. On response_enable: if discard, clear discard (no push);
//         else push {addr, data}. Go to IDLE.
//   Space is checked at issue. count cannot rise during WAIT, so a push never overflows.
//  flush, highest priority, applied at the edge where flush=1:
//   - queue emptied (count<=0, ptrs<=0); the same-cycle pop and push are both dropped.
//   - fetch_pc <= {redirect_pc[31:2], 2'b00}; no request is issued in the flush cycle.
//   - in WAIT with no response_enable: discard<=1 and stay in WAIT.
//   - in WAIT with response_enable in the same cycle: drop the word and go to IDLE (discard stays 0).
//   - repeated flush while discard=1: discard stays 1 and fetch_pc takes the latest redirect_pc.
//  Queue: pop = instr_valid & instr_ready & !flush. Push and pop in the same cycle leave count
//   unchanged. Pointers wrap mod DEPTH. instr_valid = (count!=0). instr_raw/instr_pc are read
//   combinationally at rd ptr and are don't-care while instr_valid=0.
//  Latency: issue edge E puts request_enable high in cycle E+1. A response in cycle R gives
//   instr_valid=1 from cycle R+1. In IDLE with space, the next request issues at the edge after
//   the response edge. Throughput is 1 word per (bus latency + 2) cycles.
//  Full: at count==DEPTH no request issues. The next issue comes on the edge after a pop.
// TESTING
//  1 reset, instr_ready=1, bus latency 1 -> requests addr 0,4,8,...; instr_pc/raw pairs match,
//    in order.
//  2 DEPTH=4, instr_ready=0 -> exactly 4 requests (0..C), count=4, request_enable stays 0;
//    one pop -> request to 0x10.
//  3 flush redirect_pc=0x100 while WAIT for 0x8 -> 0x8 data dropped, count=0;
//    next request addr=0x100, first instr_pc=0x100.
//  4 flush in the same cycle as response_enable and pop -> nothing pushed, count=0, next addr=redirect_pc.
//  5 redirect_pc=0xFFFFFFFC -> requests 0xFFFFFFFC then 0x0; redirect_pc=0x103 -> addr 0x100.
//  6 deassert rstn during WAIT, then response_enable after release -> ignored,
//    first request addr=RESET_PC, count=0.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: prefetching instruction fetch unit.
// Owns the fetch PC, keeps at most one read outstanding on the shared memory
// bus, and buffers returned words with their PCs in a DEPTH-entry FIFO that
// decode drains over a valid/ready handshake. A redirect (flush) empties the
// FIFO and discards the in-flight word when it eventually returns.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] PC_STEP  = 32'd4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       flush,
    input  logic [31:0]                redirect_pc,
    output logic                       request_enable,
    output logic                       mode,
    output logic [31:0]                addr,
    output logic [31:0]                wdata,
    output logic [3:0]                 wstrb,
    input  logic                       response_enable,
    input  logic [31:0]                data,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [31:0]                instr_raw,
    output logic [31:0]                instr_pc,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int   AW          = $clog2(DEPTH);
    localparam int   CW          = AW + 1;
    localparam logic MEMREQ_READ = 1'b0;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t          state_r;
    logic [31:0]     fetch_pc_r;
    logic            discard_r;
    logic            request_enable_r;
    logic [31:0]     addr_r;

    logic [63:0]     mem_r [DEPTH];
    logic [AW-1:0]   rd_ptr_r;
    logic [AW-1:0]   wr_ptr_r;
    logic [CW-1:0]   count_r;

    logic            push_s;
    logic            pop_s;
    logic            has_space_s;
    logic [63:0]     head_s;

    // Queue handshakes; a flush cancels both the pop and the push of its cycle.
    always_comb begin
        push_s      = 1'b0;
        pop_s       = 1'b0;
        has_space_s = (count_r < CW'(DEPTH));
        if (flush) begin
            push_s = 1'b0;
            pop_s  = 1'b0;
        end else begin
            push_s = (state_r == ST_WAIT) && response_enable && !discard_r;
            pop_s  = (count_r != {CW{1'b0}}) && instr_ready;
        end
    end

    // Fetch control FSM: issue one read at a time, handle redirects and stale returns.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r          <= ST_IDLE;
            fetch_pc_r       <= RESET_PC;
            discard_r        <= 1'b0;
            request_enable_r <= 1'b0;
            addr_r           <= 32'h0000_0000;
        end else if (flush) begin
            // Low two bits are forced to zero so the fetch PC stays word aligned.
            fetch_pc_r       <= redirect_pc & 32'hFFFF_FFFC;
            request_enable_r <= 1'b0;
            if (state_r == ST_WAIT) begin
                if (response_enable) begin
                    // The stale word arrives right now: drop it, nothing left in flight.
                    state_r   <= ST_IDLE;
                    discard_r <= 1'b0;
                end else begin
                    // The stale word is still coming: remember to swallow it.
                    state_r   <= ST_WAIT;
                    discard_r <= 1'b1;
                end
            end else begin
                state_r   <= ST_IDLE;
                discard_r <= discard_r;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (has_space_s) begin
                        request_enable_r <= 1'b1;
                        addr_r           <= fetch_pc_r;
                        fetch_pc_r       <= fetch_pc_r + PC_STEP;
                        state_r          <= ST_WAIT;
                    end else begin
                        request_enable_r <= 1'b0;
                        state_r          <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    request_enable_r <= 1'b0;
                    if (response_enable) begin
                        discard_r <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
                        state_r   <= ST_WAIT;
                    end
                end
                default: begin
                    request_enable_r <= 1'b0;
                    discard_r        <= 1'b0;
                    state_r          <= ST_IDLE;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; space is reserved at issue so a push never overflows.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage: {pc, instr} per entry; contents are meaningless until pushed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {addr_r, data};
        end
    end

    assign head_s         = mem_r[rd_ptr_r];
    assign instr_pc       = head_s[63:32];
    assign instr_raw      = head_s[31:0];
    assign instr_valid    = (count_r != {CW{1'b0}});
    assign count          = count_r;
    assign request_enable = request_enable_r;
    assign addr           = addr_r;
    assign mode           = MEMREQ_READ;
    assign wdata          = 32'h0000_0000;
    assign wstrb          = 4'h0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a one-cycle-latency bus responder driven
// from tasks, with hand-derived expected addresses, PCs and occupancies.
module tb_fetch_queue;

    localparam logic [31:0] K = 32'h1357_9BDF;  // read data = address ^ K

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        request_enable;
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        response_enable = 1'b0;
    logic [31:0] data = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_raw;
    logic [31:0] instr_pc;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_bad = 0;
    int n_req = 0;

    fetch_queue #(.DEPTH(4), .PC_STEP(32'd4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .redirect_pc(redirect_pc),
        .request_enable(request_enable), .mode(mode), .addr(addr),
        .wdata(wdata), .wstrb(wstrb), .response_enable(response_enable),
        .data(data), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_raw(instr_raw), .instr_pc(instr_pc), .count(count)
    );

    always #5 clk = ~clk;

    // Count request pulses seen by the bus.
    always @(posedge clk) begin
        if (request_enable === 1'b1) n_req <= n_req + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 1'b0; flush = 1'b0; response_enable = 1'b0; instr_ready = 1'b0;
        tick(); tick();
        rstn = 1'b1;
    endtask

    task automatic wait_req(output logic [31:0] a);
        a = 32'h0;
        for (int k = 0; k < 40 && request_enable !== 1'b1; k++) tick();
        check_eq("req_seen", {63'd0, request_enable}, 64'd1);
        a = addr;
    endtask

    // Wait for a request, check its address, answer one cycle later.
    task automatic fetch(input logic [31:0] exp);
        logic [31:0] a;
        wait_req(a);
        check_eq("req_addr", {32'd0, a}, {32'd0, exp});
        tick();
        response_enable = 1'b1; data = a ^ K;
        tick();
        response_enable = 1'b0; data = 32'h0;
    endtask

    initial begin
        logic [31:0] a;
        int base;

        // ---- 1: reset state, then streaming with consumer always ready ----
        tick();
        check_eq("rst_req", {63'd0, request_enable}, 64'd0);
        check_eq("rst_valid", {63'd0, instr_valid}, 64'd0);
        check_eq("rst_count", {61'd0, count}, 64'd0);
        check_eq("rst_addr", {32'd0, addr}, 64'd0);
        check_eq("const_bus", {27'd0, mode, wdata, wstrb}, 64'd0);
        do_reset();
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fetch(32'(i * 4));
            check_eq("t1_valid", {63'd0, instr_valid}, 64'd1);
            check_eq("t1_pc", {32'd0, instr_pc}, {32'd0, 32'(i * 4)});
            check_eq("t1_raw", {32'd0, instr_raw}, {32'd0, 32'(i * 4) ^ K});
        end

        // ---- 2: consumer stalled, queue fills, one pop releases a request ----
        do_reset();
        base = n_req;
        fetch(32'h0); fetch(32'h4); fetch(32'h8); fetch(32'hC);
        repeat (5) tick();
        check_eq("t2_count_full", {61'd0, count}, 64'd4);
        check_eq("t2_req_idle", {63'd0, request_enable}, 64'd0);
        check_eq("t2_nreq", 64'(n_req - base), 64'd4);
        check_eq("t2_head_pc", {32'd0, instr_pc}, 64'h0);
        check_eq("t2_head_raw", {32'd0, instr_raw}, {32'd0, K});
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check_eq("t2_count_pop", {61'd0, count}, 64'd3);
        check_eq("t2_head_pc2", {32'd0, instr_pc}, 64'h4);
        wait_req(a);
        check_eq("t2_addr_10", {32'd0, a}, 64'h10);

        // ---- 3: flush while waiting for 0x8, stale word swallowed ----
        do_reset();
        instr_ready = 1'b1;
        fetch(32'h0); fetch(32'h4);
        wait_req(a);
        check_eq("t3_addr8", {32'd0, a}, 64'h8);
        flush = 1'b1; redirect_pc = 32'h100;
        tick();
        flush = 1'b0;
        response_enable = 1'b1; data = 32'hBAD0_0008;
        tick();
        response_enable = 1'b0;
        check_eq("t3_count", {61'd0, count}, 64'd0);
        check_eq("t3_valid", {63'd0, instr_valid}, 64'd0);
        instr_ready = 1'b0;
        fetch(32'h100);
        check_eq("t3_pc", {32'd0, instr_pc}, 64'h100);
        check_eq("t3_raw", {32'd0, instr_raw}, {32'd0, 32'h100 ^ K});

        // ---- 3b: back-to-back flushes, latest redirect wins ----
        wait_req(a);
        flush = 1'b1; redirect_pc = 32'h300;
        tick();
        redirect_pc = 32'h340;
        tick();
        flush = 1'b0;
        response_enable = 1'b1; data = 32'hBAD0_0104;
        tick();
        response_enable = 1'b0;
        check_eq("t3b_count", {61'd0, count}, 64'd0);
        fetch(32'h340);
        check_eq("t3b_pc", {32'd0, instr_pc}, 64'h340);

        // ---- 4: flush coincides with response and pop ----
        do_reset();
        fetch(32'h0);
        wait_req(a);
        tick();
        response_enable = 1'b1; data = a ^ K;
        flush = 1'b1; redirect_pc = 32'h200; instr_ready = 1'b1;
        tick();
        response_enable = 1'b0; flush = 1'b0; instr_ready = 1'b0;
        check_eq("t4_count", {61'd0, count}, 64'd0);
        check_eq("t4_valid", {63'd0, instr_valid}, 64'd0);
        fetch(32'h200);
        check_eq("t4_pc", {32'd0, instr_pc}, 64'h200);
        check_eq("t4_count1", {61'd0, count}, 64'd1);

        // ---- 5: PC wraps at 2^32; unaligned redirect is aligned ----
        flush = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        flush = 1'b0;
        fetch(32'hFFFF_FFFC);
        check_eq("t5_pc_top", {32'd0, instr_pc}, 64'hFFFF_FFFC);
        fetch(32'h0);
        check_eq("t5_count2", {61'd0, count}, 64'd2);
        flush = 1'b1; redirect_pc = 32'h103;
        tick();
        flush = 1'b0;
        check_eq("t5_count0", {61'd0, count}, 64'd0);
        wait_req(a);
        check_eq("t5_aligned", {32'd0, a}, 64'h100);

        // ---- 6: reset during WAIT, late response ignored ----
        tick();
        rstn = 1'b0;
        tick();
        check_eq("t6_rst_req", {63'd0, request_enable}, 64'd0);
        rstn = 1'b1;
        response_enable = 1'b1; data = 32'hBAD0_0100;
        tick();
        response_enable = 1'b0;
        check_eq("t6_count", {61'd0, count}, 64'd0);
        check_eq("t6_req", {63'd0, request_enable}, 64'd1);
        check_eq("t6_addr", {32'd0, addr}, 64'h0);
        tick(); tick();
        check_eq("t6_valid", {63'd0, instr_valid}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
